// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a payload, then sends header/payload/parity under busy back-pressure.
// Optional ROUTER_TX_PARITY_ERR_INJ_EN adds inj_err, which flips parity bit 0 of the packet it is accepted with.
module router_pkt_tx #(
   parameter int MAX_LEN = 63
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_vld,
   input  logic [1:0] req_addr,
   input  logic [5:0] req_len,
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
   input  logic       inj_err,
`endif
   output logic       req_rdy,
   output logic       req_err,
   input  logic [7:0] src_data,
   input  logic       src_vld,
   output logic       src_rdy,
   input  logic       busy,
   output logic       pkt_vld,
   output logic [7:0] data_out,
   output logic       done
);

   localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_HEADER, S_PAYLOAD, S_PARITY, S_DONE
   } state_t;

   state_t     r_state;
   logic [1:0] r_addr;
   logic [5:0] r_len;
   logic [5:0] r_cnt;
   logic [5:0] r_idx;
   logic [7:0] r_parity;
   logic       r_inj;
   logic       r_pkt_vld;
   logic [7:0] r_data_out;
   logic       r_req_err;
   logic [7:0] r_buf [0:63];

   logic       w_req_legal;
   logic       w_inj_req;
   logic [7:0] w_hdr;

`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
   assign w_inj_req = inj_err;
`else
   assign w_inj_req = 1'b0;
`endif

   assign w_req_legal = (req_addr != 2'd3) && (req_len != 6'd0) && ({1'b0, req_len} <= LEN_MAX);
   assign w_hdr       = {r_len, r_addr};

   assign req_rdy  = (r_state == S_IDLE);
   assign src_rdy  = (r_state == S_FILL);
   assign done     = (r_state == S_DONE);
   assign req_err  = r_req_err;
   assign pkt_vld  = r_pkt_vld;
   assign data_out = r_data_out;

   // Payload storage is deliberately left out of reset; contents are only read after a full fill.
   always_ff @(posedge clk) begin
      if (r_state == S_FILL && src_vld) begin
         r_buf[r_cnt] <= src_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_addr     <= 2'd0;
         r_len      <= 6'd0;
         r_cnt      <= 6'd0;
         r_idx      <= 6'd0;
         r_parity   <= 8'h00;
         r_inj      <= 1'b0;
         r_pkt_vld  <= 1'b0;
         r_data_out <= 8'h00;
         r_req_err  <= 1'b0;
      end else begin
         r_req_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_vld) begin
                  if (w_req_legal) begin
                     r_addr   <= req_addr;
                     r_len    <= req_len;
                     r_parity <= {req_len, req_addr};
                     r_cnt    <= 6'd0;
                     r_inj    <= w_inj_req;
                     r_state  <= S_FILL;
                  end else begin
                     r_req_err <= 1'b1;
                  end
               end
            end
            S_FILL: begin
               if (src_vld) begin
                  r_parity <= r_parity ^ src_data;
                  r_cnt    <= r_cnt + 6'd1;
                  if (r_cnt == r_len - 6'd1) begin
                     r_state    <= S_HEADER;
                     r_pkt_vld  <= 1'b1;
                     r_data_out <= w_hdr;
                  end
               end
            end
            S_HEADER: begin
               if (!busy) begin
                  r_state    <= S_PAYLOAD;
                  r_idx      <= 6'd0;
                  r_data_out <= r_buf[0];
               end
            end
            S_PAYLOAD: begin
               if (!busy) begin
                  r_idx <= r_idx + 6'd1;
                  if (r_idx == r_len - 6'd1) begin
                     r_state    <= S_PARITY;
                     r_pkt_vld  <= 1'b0;
                     r_data_out <= r_parity ^ {7'd0, r_inj};
                  end else begin
                     r_data_out <= r_buf[r_idx + 6'd1];
                  end
               end
            end
            S_PARITY: begin
               if (!busy) begin
                  r_state    <= S_DONE;
                  r_data_out <= 8'h00;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: table of packet requests checked through a byte scoreboard, plus hold and reset sequences.
module tb_router_pkt_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_vld = 1'b0;
   logic [1:0] req_addr = 2'd0;
   logic [5:0] req_len = 6'd0;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
   logic       inj_err = 1'b0;
`endif
   logic       req_rdy, req_err, src_rdy, pkt_vld, done;
   logic [7:0] src_data = 8'h00;
   logic       src_vld = 1'b0;
   logic       busy = 1'b0;
   logic [7:0] data_out;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] addr;
      logic [5:0] len;
      logic       inj;
      logic [7:0] p0;
      logic [7:0] step;
      int         busy_pct;
      logic       exp_err;
      logic [7:0] exp_hdr;
      logic       has_par;
      logic [7:0] exp_par;
   } vec_t;

   logic [8:0] sb [$];
   bit         in_pkt = 0;
   bit         expect_done = 0;
   bit         chk_done_low = 0;
   int         busy_pct = 0;
   bit         busy_manual = 0;
   bit         busy_man = 0;
   logic [8:0] e_mon;

   router_pkt_tx dut (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr), .req_len(req_len),
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
      .inj_err(inj_err),
`endif
      .req_rdy(req_rdy), .req_err(req_err), .src_data(src_data), .src_vld(src_vld),
      .src_rdy(src_rdy), .busy(busy), .pkt_vld(pkt_vld), .data_out(data_out), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (busy_manual) busy = busy_man;
      else busy = (int'($urandom_range(0, 99)) < busy_pct);
   end

   // Bytes are taken on the next rising edge when busy is low; parity is the pkt_vld=0 byte ending a packet.
   always @(negedge clk) begin
      if (!rst) begin
         if (expect_done) begin
            chk("done_pulse", {31'd0, done}, 1);
            expect_done = 0;
            chk_done_low = 1;
         end else if (chk_done_low) begin
            chk("done_width", {31'd0, done}, 0);
            chk_done_low = 0;
         end
         if (!busy && (pkt_vld || in_pkt)) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected_byte actual=%0h required=none", {pkt_vld, data_out});
            end else begin
               e_mon = sb.pop_front();
               chk("tx_byte", {23'd0, pkt_vld, data_out}, {23'd0, e_mon});
               if (pkt_vld) in_pkt = 1;
               else begin
                  in_pkt = 0;
                  expect_done = 1;
               end
            end
         end
      end
   end

   task automatic issue(input vec_t v);
      int n, k;
      logic [7:0] par, b;
      bit hs;
      n = 0;
      while (!req_rdy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_rdy_wait", {31'd0, req_rdy}, 1);
      req_vld = 1'b1;
      req_addr = v.addr;
      req_len = v.len;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
      inj_err = v.inj;
`endif
      @(posedge clk); #1;
      req_vld = 1'b0;
      if (v.exp_err) begin
         @(negedge clk);
         chk("req_err_pulse", {31'd0, req_err}, 1);
         chk("req_rdy_after_err", {31'd0, req_rdy}, 1);
         chk("pkt_vld_after_err", {31'd0, pkt_vld}, 0);
         @(negedge clk);
         chk("req_err_width", {31'd0, req_err}, 0);
         return;
      end
      @(negedge clk);
      chk("req_rdy_in_fill", {31'd0, req_rdy}, 0);
      chk("src_rdy_in_fill", {31'd0, src_rdy}, 1);
      sb.push_back({1'b1, v.exp_hdr});
      par = {v.len, v.addr};
      @(posedge clk); #1;
      k = 0;
      n = 0;
      while (k < int'(v.len) && n < 5000) begin
         b = v.p0 + 8'(k) * v.step;
         src_vld = ($urandom_range(0, 3) != 0);
         src_data = b;
         @(negedge clk);
         hs = src_vld && src_rdy;
         if (hs) begin
            sb.push_back({1'b1, b});
            par = par ^ b;
         end
         @(posedge clk); #1;
         if (hs) k++;
         n++;
      end
      src_vld = 1'b0;
      chk("fill_count", k, {26'd0, v.len});
      sb.push_back({1'b0, v.has_par ? v.exp_par : (par ^ {7'd0, v.inj})});
   endtask

   task automatic wait_done();
      int n = 0;
      while ((sb.size() != 0 || in_pkt || expect_done || chk_done_low) && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("pkt_drain", sb.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[$];
      vec_t v0, vr;
      int held;

      vt.push_back('{2'd1, 6'd3,  1'b0, 8'h11, 8'h11, 0,  1'b0, 8'h0D, 1'b1, 8'h0D});
      vt.push_back('{2'd3, 6'd3,  1'b0, 8'h00, 8'h00, 0,  1'b1, 8'h00, 1'b0, 8'h00});
      vt.push_back('{2'd0, 6'd0,  1'b0, 8'h00, 8'h00, 0,  1'b1, 8'h00, 1'b0, 8'h00});
      vt.push_back('{2'd2, 6'd1,  1'b0, 8'hA5, 8'h00, 0,  1'b0, 8'h06, 1'b1, 8'hA3});
      vt.push_back('{2'd0, 6'd63, 1'b0, 8'h3C, 8'h05, 30, 1'b0, 8'hFC, 1'b0, 8'h00});
      vt.push_back('{2'd2, 6'd5,  1'b0, 8'hF0, 8'h13, 50, 1'b0, 8'h16, 1'b0, 8'h00});
      vt.push_back('{2'd1, 6'd2,  1'b0, 8'h01, 8'h01, 70, 1'b0, 8'h09, 1'b0, 8'h00});
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
      vt.push_back('{2'd1, 6'd3,  1'b1, 8'h11, 8'h11, 0,  1'b0, 8'h0D, 1'b1, 8'h0C});
`endif
      v0 = vt[0];

      repeat (2) @(posedge clk);
      #1;
      chk("rst_pkt_vld", {31'd0, pkt_vld}, 0);
      chk("rst_data_out", {24'd0, data_out}, 0);
      chk("rst_req_rdy", {31'd0, req_rdy}, 1);
      chk("rst_src_rdy", {31'd0, src_rdy}, 0);
      chk("rst_req_err", {31'd0, req_err}, 0);
      chk("rst_done", {31'd0, done}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < vt.size(); i++) begin
         busy_pct = vt[i].busy_pct;
         issue(vt[i]);
         if (!vt[i].exp_err) wait_done();
      end

      // Header held under busy: four busy edges plus the accepting cycle.
      busy_pct = 0;
      busy_manual = 1;
      busy_man = 1;
      issue(v0);
      held = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (pkt_vld && data_out == 8'h0D) held++;
         if (c == 3) busy_man = 0;
      end
      chk("header_hold_cycles", held, 5);
      wait_done();
      busy_manual = 0;

      // Reset in the middle of the payload phase, then a clean packet.
      vr = '{2'd0, 6'd10, 1'b0, 8'h40, 8'h01, 0, 1'b0, 8'h28, 1'b0, 8'h00};
      issue(vr);
      for (int c = 0; c < 200 && sb.size() > 8; c++) begin
         @(posedge clk); #1;
      end
      chk("midpkt_progress", {31'd0, pkt_vld}, 1);
      rst = 1'b1;
      #1;
      chk("midrst_pkt_vld", {31'd0, pkt_vld}, 0);
      chk("midrst_req_rdy", {31'd0, req_rdy}, 1);
      chk("midrst_src_rdy", {31'd0, src_rdy}, 0);
      chk("midrst_data_out", {24'd0, data_out}, 0);
      sb.delete();
      in_pkt = 0;
      expect_done = 0;
      chk_done_low = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      issue(v0);
      wait_done();

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
